afifo_rd_sched: RTL

//  Read-domain scheduler for the async FIFO. Owns the read pointer (binary + Gray) and derives empty/level

---
 rtl/afifo_rd_sched_if.sv | 27 ++
 rtl/afifo_rd_sched.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/afifo_rd_sched_if.sv
// Consumer-side bundle of the async FIFO read scheduler: requests and lengths in, grant and data-valid tags out.
// The scheduler takes the slave view and the consumer group (or bench) takes the master view.
interface afifo_rd_sched_if #(
   parameter int NUM_REQ = 4,
   parameter int LW      = 3
);
   localparam int IW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]    req;
   logic [NUM_REQ*LW-1:0] req_len;
   logic                  rd_rdy;
   logic [NUM_REQ-1:0]    gnt;
   logic                  data_vld;
   logic [IW-1:0]         vld_id;
   logic                  burst_done;
   logic                  burst_to;

   modport master (
      output req, req_len, rd_rdy,
      input  gnt, data_vld, vld_id, burst_done, burst_to
   );

   modport slave (
      input  req, req_len, rd_rdy,
      output gnt, data_vld, vld_id, burst_done, burst_to
   );
endinterface

// File: rtl/afifo_rd_sched.sv
// Async FIFO read-side scheduler: owns the read pointer and round-robins pop bursts among consumers; data_vld lags rd_en by one cycle.
// rd_rdy low or empty stalls with grant held; `RD_TIMEOUT_EN adds a stall timeout that aborts the burst.
module afifo_rd_sched #(
   parameter int DEPTH     = 16,
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 4,
   parameter int TIMEOUT   = 8
) (
   input  logic                            r_clk,
   input  logic                            rst,
   input  logic [$clog2(DEPTH):0]          rsync_wptr,
   output logic [$clog2(DEPTH):0]          rptr_gray,
   output logic [$clog2(DEPTH)-1:0]        rd_addr,
   output logic                            rd_en,
   output logic                            empty,
   output logic [$clog2(DEPTH):0]          rd_level,
   afifo_rd_sched_if.slave                 cons
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(MAX_BURST + 1);
   localparam int IW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [AW:0]        rbin_q, rbin_d;
   logic [AW:0]        rgray_q;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [IW-1:0]      gidx_q, gidx_d;
   logic [IW-1:0]      rr_last_q, rr_last_d;
   logic [LW-1:0]      cnt_q, cnt_d;
   logic               data_vld_q;
   logic [IW-1:0]      vld_id_q;

   logic               pop;
   logic               pick_vld;
   logic [IW-1:0]      pick;
   logic [LW-1:0]      raw_len;
   logic [LW-1:0]      pick_len;
   int                 idx;

`ifdef RD_TIMEOUT_EN
   localparam int SW = $clog2(TIMEOUT + 1);
   logic [SW-1:0]      stall_q, stall_d;
   logic               to_q, to_d;
`endif

   function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
      logic [AW:0] b;
      b[AW] = g[AW];
      for (int i = AW - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   assign empty    = (rgray_q == rsync_wptr);
   assign rd_level = gray2bin(rsync_wptr) - rbin_q;
   assign rd_addr  = rbin_q[AW-1:0];
   assign rptr_gray = rgray_q;

   // A dropped request aborts without popping, so the grantee's req gates the strobe.
   assign pop   = (state_q == BURST) && !empty && cons.rd_rdy && cons.req[gidx_q];
   assign rd_en = pop;

   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      idx      = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(rr_last_q) + k) % NUM_REQ;
         if (!pick_vld && cons.req[idx]) begin
            pick_vld = 1'b1;
            pick     = IW'(idx);
         end
      end
      raw_len = cons.req_len[int'(pick)*LW +: LW];
      if (raw_len == '0) begin
         pick_len = LW'(1);
      end else if (raw_len > LW'(MAX_BURST)) begin
         pick_len = LW'(MAX_BURST);
      end else begin
         pick_len = raw_len;
      end
   end

   always_comb begin
      state_d   = state_q;
      rbin_d    = rbin_q;
      gnt_d     = gnt_q;
      gidx_d    = gidx_q;
      cnt_d     = cnt_q;
      rr_last_d = rr_last_q;
`ifdef RD_TIMEOUT_EN
      stall_d   = stall_q;
      to_d      = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               state_d     = BURST;
               gnt_d       = '0;
               gnt_d[pick] = 1'b1;
               gidx_d      = pick;
               cnt_d       = pick_len;
`ifdef RD_TIMEOUT_EN
               stall_d     = '0;
`endif
            end
         end
         BURST: begin
            if (!cons.req[gidx_q]) begin
               state_d = DONE;
               gnt_d   = '0;
            end else if (pop) begin
               rbin_d = rbin_q + 1'b1;
               cnt_d  = cnt_q - 1'b1;
`ifdef RD_TIMEOUT_EN
               stall_d = '0;
`endif
               if (cnt_q == LW'(1)) begin
                  state_d = DONE;
                  gnt_d   = '0;
               end
`ifdef RD_TIMEOUT_EN
            end else if (empty) begin
               if (stall_q == SW'(TIMEOUT - 1)) begin
                  state_d = DONE;
                  gnt_d   = '0;
                  to_d    = 1'b1;
               end else begin
                  stall_d = stall_q + 1'b1;
               end
`endif
            end
         end
         DONE: begin
            state_d   = IDLE;
            rr_last_d = gidx_q;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge r_clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rbin_q     <= '0;
         rgray_q    <= '0;
         gnt_q      <= '0;
         gidx_q     <= '0;
         cnt_q      <= '0;
         rr_last_q  <= IW'(NUM_REQ - 1);
         data_vld_q <= 1'b0;
         vld_id_q   <= '0;
`ifdef RD_TIMEOUT_EN
         stall_q    <= '0;
         to_q       <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         rbin_q     <= rbin_d;
         rgray_q    <= bin2gray(rbin_d);
         gnt_q      <= gnt_d;
         gidx_q     <= gidx_d;
         cnt_q      <= cnt_d;
         rr_last_q  <= rr_last_d;
         data_vld_q <= pop;
         vld_id_q   <= gidx_q;
`ifdef RD_TIMEOUT_EN
         stall_q    <= stall_d;
         to_q       <= to_d;
`endif
      end
   end

   assign cons.gnt        = gnt_q;
   assign cons.data_vld   = data_vld_q;
   assign cons.vld_id     = vld_id_q;
   assign cons.burst_done = (state_q == DONE);
`ifdef RD_TIMEOUT_EN
   assign cons.burst_to   = to_q;
`else
   assign cons.burst_to   = 1'b0;
`endif
endmodule
